// File: rtl/dev_ram_arbiter.sv
// dev_ram_arbiter: request/grant arbiter sharing one dev_ram between two requesters, one access in flight.
// Optional macro DEV_RAM_ARBITER_PRIO0_EN: fixed priority to port 0 instead of round-robin.
module dev_ram_arbiter #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 64,  // pkg_ram::RAM_QUAD_SIZE
  parameter int unsigned RD_LAT = 1    // legal range 1..7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [1:0]        size0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [1:0]        size1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [1:0]        ram_size,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_e;

  localparam logic [2:0] LAT_LOAD = 3'(RD_LAT - 1);

  state_e     state;
  logic       owner;
  logic [2:0] cnt;
  logic       pick;

`ifdef DEV_RAM_ARBITER_PRIO0_EN
  always_comb begin
    pick = ~req0;
  end
`else
  logic last;

  // On a tie the port that did not win last time goes first.
  always_comb begin
    pick = (req0 && req1) ? ~last : req1;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      owner     <= 1'b0;
      cnt       <= '0;
`ifndef DEV_RAM_ARBITER_PRIO0_EN
      last      <= 1'b1;
`endif
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_size  <= '0;
      ram_wdata <= '0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            owner     <= pick;
`ifndef DEV_RAM_ARBITER_PRIO0_EN
            last      <= pick;
`endif
            gnt0      <= ~pick;
            gnt1      <= pick;
            ram_en    <= 1'b1;
            ram_we    <= pick ? we1    : we0;
            ram_addr  <= pick ? addr1  : addr0;
            ram_size  <= pick ? size1  : size0;
            ram_wdata <= pick ? wdata1 : wdata0;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          ram_en <= 1'b0;
          gnt0   <= 1'b0;
          gnt1   <= 1'b0;
          cnt    <= LAT_LOAD;
          state  <= WAIT;
        end
        WAIT: begin
          // Counter hits zero in the cycle ram_rdata is valid, RD_LAT cycles after ram_en.
          if (cnt == '0) begin
            if (owner) begin
              rdata1 <= ram_rdata;
              done1  <= 1'b1;
            end else begin
              rdata0 <= ram_rdata;
              done0  <= 1'b1;
            end
            state <= IDLE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dev_ram_arbiter.sv
// Self-checking bench for dev_ram_arbiter: directed plan steps plus randomized two-port traffic
// checked against a transaction-level model (round-robin rule, fixed latency, reference memory).
module tb_dev_ram_arbiter;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned RD_LAT = 3;
`ifdef DEV_RAM_ARBITER_PRIO0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req0, we0, req1, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [1:0]        size0, size1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1, done0, done1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [1:0]        ram_size;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata = '0;

  dev_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .size0(size0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .size1(size1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata0(rdata0), .rdata1(rdata1),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_size(ram_size),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic              pend    [2];
  logic              c_we    [2];
  logic [ADDR_W-1:0] c_addr  [2];
  logic [1:0]        c_size  [2];
  logic [DATA_W-1:0] c_wdata [2];
  logic              rd_valid[2];
  logic [DATA_W-1:0] exp_rd  [2];
  logic              exp_last = 1'b1;

  logic [DATA_W-1:0] ram_mem [logic [ADDR_W-1:0]];
  logic [DATA_W-1:0] ref_mem [logic [ADDR_W-1:0]];

  function automatic logic [DATA_W-1:0] dflt(input logic [ADDR_W-1:0] a);
    return {4{a}};
  endfunction

  function automatic logic [DATA_W-1:0] mem_read(input logic [ADDR_W-1:0] a);
    return ram_mem.exists(a) ? ram_mem[a] : dflt(a);
  endfunction

  function automatic logic [DATA_W-1:0] ref_read(input logic [ADDR_W-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  // RAM model: data valid only in the cycle RD_LAT after the strobe, garbage otherwise.
  int                rm_cnt  = 0;
  bit                rm_busy = 1'b0;
  logic [DATA_W-1:0] rm_data = '0;
  always @(negedge clk) begin
    if (rm_cnt > 0) rm_cnt = rm_cnt - 1;
    if (rm_busy && rm_cnt == 0) begin
      ram_rdata = rm_data;
      rm_busy   = 1'b0;
    end else begin
      ram_rdata = {$urandom, $urandom};
    end
    if (ram_en) begin
      if (ram_we) ram_mem[ram_addr] = ram_wdata;
      rm_data = mem_read(ram_addr);
      rm_busy = 1'b1;
      rm_cnt  = RD_LAT;
    end
  end

  task automatic tick();
    @(posedge clk);
    cyc = cyc + 1;
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert = n_assert + 1;
    assert (obs === exp) else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    req0 = pend[0]; we0 = c_we[0]; addr0 = c_addr[0]; size0 = c_size[0]; wdata0 = c_wdata[0];
    req1 = pend[1]; we1 = c_we[1]; addr1 = c_addr[1]; size1 = c_size[1]; wdata1 = c_wdata[1];
  endtask

  task automatic new_cmd(input int p);
    c_we[p]    = 1'($urandom_range(0, 1));
    c_addr[p]  = ADDR_W'($urandom_range(0, 7) * 8);
    c_size[p]  = 2'($urandom_range(0, 3));
    c_wdata[p] = {$urandom, $urandom};
  endtask

  function automatic int winner();
    if (pend[0] && pend[1]) return PRIO0 ? 0 : (exp_last ? 0 : 1);
    return pend[1] ? 1 : 0;
  endfunction

  // One arbitration round starting in an IDLE cycle; returns the winner, or 2 when nobody requested.
  task automatic step(output int w);
    logic [DATA_W-1:0] er;
    er = '0;
    drive();
    if (!pend[0] && !pend[1]) begin
      w = 2;
      tick();
      chk("idle_quiet", {gnt1, gnt0, ram_en}, 0);
      return;
    end
    w = winner();
    exp_last = (w == 1);
    tick();
    chk("grant", {done1, done0, gnt1, gnt0}, (w == 1) ? 4'b0010 : 4'b0001);
    chk("ram_en", ram_en, 1);
    chk("ram_we", ram_we, c_we[w]);
    chk("ram_addr", ram_addr, c_addr[w]);
    chk("ram_size", ram_size, c_size[w]);
    chk("ram_wdata", ram_wdata, c_wdata[w]);
    if (c_we[w]) ref_mem[c_addr[w]] = c_wdata[w];
    else er = ref_read(c_addr[w]);
    pend[w] = 1'b0;
    drive();
    repeat (RD_LAT) begin
      tick();
      chk("wait_quiet", {done1, done0, gnt1, gnt0, ram_en}, 0);
    end
    tick();
    chk("done", {done1, done0}, (w == 1) ? 2'b10 : 2'b01);
    if (!c_we[w]) begin
      chk("rdata", (w == 1) ? rdata1 : rdata0, er);
      rd_valid[w] = 1'b1;
      exp_rd[w]   = er;
    end else begin
      rd_valid[w] = 1'b0;
    end
    if (rd_valid[1-w]) chk("rdata_hold", (w == 1) ? rdata0 : rdata1, exp_rd[1-w]);
  endtask

  initial begin
    int w, prev, to, just_done;
    rst = 1'b0;
    ram_mem[16'h0010] = 64'hAB;
    ref_mem[16'h0010] = 64'hAB;
    for (int p = 0; p < 2; p++) begin
      rd_valid[p] = 1'b0;
      exp_rd[p]   = '0;
      new_cmd(p);
      c_we[p]     = 1'b0;
      pend[p]     = 1'b1;
    end
    c_addr[0] = 16'h0010;
    c_addr[1] = 16'h0020;
    drive();

    // Reset held with both requests high
    repeat (3) begin
      tick();
      chk("rst_ctrl", {gnt1, gnt0, done1, done0, ram_en, ram_we, ram_size}, 0);
      chk("rst_bus", ram_addr ^ 16'(ram_wdata), 0);
      chk("rst_wdata", ram_wdata, 0);
      chk("rst_rdata", rdata0 | rdata1, 0);
    end
    rst = 1'b1;
    exp_last = 1'b1;
    step(w);
    chk("first_tie_port0", w, 0);
    step(w);
    step(w);

    // Single read of 0x0010
    pend[0] = 1'b1; c_we[0] = 1'b0; c_addr[0] = 16'h0010; c_size[0] = 2'd3;
    step(w);
    chk("single_read_ab", rdata0, 64'hAB);
    step(w);

    // Port 1 write then read back
    pend[1] = 1'b1; c_we[1] = 1'b1; c_addr[1] = 16'h0008; c_size[1] = 2'd3;
    c_wdata[1] = 64'h1122334455667788;
    step(w);
    step(w);
    pend[1] = 1'b1; c_we[1] = 1'b0; c_wdata[1] = '0;
    step(w);
    chk("write_readback", rdata1, 64'h1122334455667788);
    step(w);

    // Both requests held for 8 grants
    pend[0] = 1'b1; pend[1] = 1'b1;
    c_we[0] = 1'b0; c_we[1] = 1'b0;
    c_addr[0] = 16'h0010; c_addr[1] = 16'h0008;
    drive();
    prev = 0;
    for (int g = 0; g < 8; g++) begin
      int ew;
      ew = winner();
      exp_last = (ew == 1);
      to = 0;
      do begin
        tick();
        to = to + 1;
      end while (!(gnt0 || gnt1) && to < int'(RD_LAT) + 4);
      chk("cont_grant", {gnt1, gnt0}, (ew == 1) ? 2'b10 : 2'b01);
      if (g > 0) chk("cont_spacing", cyc - prev, RD_LAT + 2);
      prev = cyc;
      w = ew;
    end
    pend[0] = 1'b0; pend[1] = 1'b0;
    drive();
    repeat (RD_LAT) tick();
    tick();
    chk("cont_last_done", {done1, done0}, (w == 1) ? 2'b10 : 2'b01);
    rd_valid[0] = 1'b0; rd_valid[1] = 1'b0;
    step(w);

    // Reset during WAIT abandons the access
    pend[0] = 1'b1; c_we[0] = 1'b0; c_addr[0] = 16'h0010;
    drive();
    tick();
    chk("mid_grant", {gnt1, gnt0}, 2'b01);
    pend[0] = 1'b0;
    drive();
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_ctrl", {gnt1, gnt0, done1, done0, ram_en, ram_we}, 0);
    chk("mid_rst_addr", ram_addr, 0);
    chk("mid_rst_rdata", rdata0, 0);
    pend[0] = 1'b1; pend[1] = 1'b1;
    drive();
    repeat (2) begin
      tick();
      chk("mid_rst_hold", {gnt1, gnt0, done1, done0, ram_en}, 0);
    end
    rst = 1'b1;
    exp_last = 1'b1;
    rd_valid[0] = 1'b1; exp_rd[0] = '0;
    rd_valid[1] = 1'b1; exp_rd[1] = '0;
    step(w);
    chk("post_rst_tie_port0", w, 0);
    step(w);
    step(w);

    // Randomized traffic
    just_done = 2;
    for (int n = 0; n < 40; ) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p]) begin
          new_cmd(p);
          if (p != just_done && $urandom_range(0, 3) != 0) pend[p] = 1'b1;
        end
      end
      step(w);
      just_done = w;
      if (w != 2) n = n + 1;
    end
    for (int k = 0; k < 2 && (pend[0] || pend[1]); k++) step(w);
    step(w);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/dev_ram_arbiter.md
# dev_ram_arbiter

Two-port arbiter that shares the single `dev_ram` instance between two independent requesters, e.g. the loader/debugger pair or a CPU instruction port and data port. It replaces the static select-based RAM switch with a request/grant handshake. It serialises accesses, routes read data back to the requester that issued the access, and guarantees fairness with round-robin selection. It sits between the requesters and `dev_ram`. It has one outstanding RAM access at a time.

## Interface
Parameters:
- `ADDR_W`, default 16: RAM byte-address width.
- `DATA_W`, default `pkg_ram::RAM_QUAD_SIZE`: data width.
- `RD_LAT`, default 1: RAM cycles from `ram_en` to valid `ram_rdata`. Legal range is 1..7.

Ports:
- `clk`  in  1: single clock. All logic is on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `req0` / `req1`  in  1: access request.
- `we0` / `we1`  in  1: 1 = write, 0 = read.
- `addr0` / `addr1`  in  `ADDR_W`: byte address.
- `size0` / `size1`  in  2: access size. 0 = byte, 1 = word, 2 = long, 3 = quad.
- `wdata0` / `wdata1`  in  `DATA_W`: write data.
- `gnt0` / `gnt1`  out  1: one-cycle pulse; the command has been accepted.
- `done0` / `done1`  out  1: one-cycle pulse; the access has completed.
- `rdata0` / `rdata1`  out  `DATA_W`: read data. Valid while `doneX` is high.
- `ram_en`  out  1: one-cycle access strobe to the RAM.
- `ram_we`  out  1: write enable.
- `ram_addr`  out  `ADDR_W`: address to the RAM.
- `ram_size`  out  2: access size to the RAM.
- `ram_wdata`  out  `DATA_W`: write data to the RAM.
- `ram_rdata`  in  `DATA_W`: read data from the RAM.

## Operation
- State machine states: IDLE, ACCESS, WAIT.
- **IDLE:**
  - `req0` and `req1` are sampled.
  - If neither is high, stay in IDLE.
  - Otherwise select a winner, latch `owner`, and register that requester's `we`/`addr`/`size`/`wdata` onto the `ram_*` outputs. Set `ram_en=1` and `gntX=1`, then go to ACCESS.
- **ACCESS (1 cycle):**
  - `ram_en` and `gntX` are high for exactly this cycle.
  - Next: clear both, load the latency counter with `RD_LAT-1`, go to WAIT.
- **WAIT:**
  - Decrement the counter each cycle.
  - At counter 0, capture `ram_rdata` into `rdata[owner]`, pulse `done[owner]`, and return to IDLE.
- Writes follow the same sequence. `rdataX` is then don't-care, but `doneX` still pulses.
- **Arbitration:** round-robin on a `last` register.
  - If both requests are high, grant the one that is not `last`.
  - If only one is high, grant it.
  - `last` updates on each grant.
- `rdataX` holds its value until the next completion for that port. `ram_addr`/`ram_size`/`ram_wdata`/`ram_we` hold after ACCESS.
- **Requester rules:**
  - Hold `reqX` and the command stable until `gntX`.
  - Drop `reqX` no later than the `doneX` cycle.
  - `reqX` high in IDLE after `done` counts as a new request.
  - `req` changes outside IDLE are ignored.
- **Reset:**
  - Reset values: state = IDLE, `last` = 1 (so port 0 wins the first tie), counter = 0.
  - All outputs reset to 0, including `rdataX` and every `ram_*` output.
  - Reset mid-access abandons the access with no `done` pulse. A write already strobed into the RAM is not undone.

## Timing
- Request high in IDLE cycle t gives:
  - `gntX` and `ram_en` in cycle t+1;
  - `doneX` and `rdataX` in cycle t+2+`RD_LAT`.
- The earliest next grant is in cycle t+3+`RD_LAT`. Throughput is one access per `RD_LAT`+2 cycles.
- Worst-case wait for a continuously requesting port is one foreign access, i.e. `RD_LAT`+2 cycles of extra latency.
- No combinational path from any input to any output. All outputs are registered.

## Configuration
- `DEV_RAM_ARBITER_PRIO0_EN`
  - **Defined:** fixed priority. Port 0 always wins a tie, `last` is not implemented, and port 1 can starve.
  - **Undefined (default):** round-robin as specified above.

## Test plan
- **Reset values:** hold `rst=0` for 3 cycles with both `req` high -> all outputs stay 0 and no `ram_en`. Release -> port 0 is granted 1 cycle after the first IDLE sample.
- **Single read, `RD_LAT=1`:** `req0`, read `addr0=0x0010`, RAM returns `0x00000000000000AB` -> `gnt0` at t+1, `done0` at t+3 with `rdata0=0xAB`, `done1` stays 0.
- **Write then read:** port 1 writes quad `0x1122334455667788` to `0x0008`, then reads it back -> `ram_we=1` only in the write ACCESS cycle, and the read returns the same value.
- **Simultaneous continuous requests, default build:** both held high for 8 accesses -> grants alternate 0,1,0,1… with each grant `RD_LAT`+2 cycles apart. With `DEV_RAM_ARBITER_PRIO0_EN` -> all 8 grants go to port 0.
- **Reset mid-access:** assert `rst` in the WAIT cycle -> no `done` pulse, and after release the state is IDLE with port 0 winning the next tie.
- **`RD_LAT=3`:** single read -> `done` at t+5, and `ram_rdata` is sampled exactly 3 cycles after `ram_en`, checked by a RAM model that drives garbage at other times.
